// File: rtl/operand_fetch.sv
// Issue stage between decode and execute: drives register-file reads, resolves
// operands with EX/MEM forwarding, stalls on load-use, and registers the result.
module operand_fetch #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [XLEN-1:0]   rf_rdata_a,
  input  logic [XLEN-1:0]   rf_rdata_b,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_wr_addr,
  input  logic [XLEN-1:0]   ex_wr_data,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_wr_addr,
  input  logic [XLEN-1:0]   mem_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_op_a,
  output logic [XLEN-1:0]   out_op_b,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       stall_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   op_a_q, op_a_d;
  logic [XLEN-1:0]   op_b_q, op_b_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic              hazard;
  logic              accept;
  logic [XLEN-1:0]   res_a;
  logic [XLEN-1:0]   res_b;

  // x0 never matches a forwarding source because s==0 is resolved first.
  function automatic logic [XLEN-1:0] resolve(input logic [REG_AW-1:0] s,
                                               input logic [XLEN-1:0]   rf);
    if (s == '0)
      return '0;
    else if (ex_wr_en && !ex_is_load && ex_wr_addr == s)
      return ex_wr_data;
    else if (mem_wr_en && mem_wr_addr == s)
      return mem_wr_data;
    else
      return rf;
  endfunction

  always_comb begin
    rf_raddr_a = in_rs1;
    rf_raddr_b = in_rs2;
    res_a      = resolve(in_rs1, rf_rdata_a);
    res_b      = resolve(in_rs2, rf_rdata_b);
    hazard     = in_valid && ex_wr_en && ex_is_load && (ex_wr_addr != '0) &&
                 ((in_use_rs1 && ex_wr_addr == in_rs1) ||
                  (in_use_rs2 && ex_wr_addr == in_rs2));
    in_ready   = !flush && !hazard && (!out_valid_q || out_ready);
    accept     = in_valid && in_ready;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    ctrl_d      = ctrl_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      op_a_d      = res_a;
      op_b_d      = res_b;
      rd_d        = in_rd;
      imm_d       = in_imm;
      pc_d        = in_pc;
      ctrl_d      = in_ctrl;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (hazard && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op_a  = op_a_q;
  assign out_op_b  = op_b_q;
  assign out_rd    = rd_q;
  assign out_imm   = imm_q;
  assign out_pc    = pc_q;
  assign out_ctrl  = ctrl_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, RF read, forwarding, load-use,
// backpressure, flush and x0 handling.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2;
  logic [31:0] in_imm, in_pc;
  logic [15:0] in_ctrl;
  logic [4:0]  rf_raddr_a, rf_raddr_b;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic        ex_wr_en, ex_is_load;
  logic [4:0]  ex_wr_addr;
  logic [31:0] ex_wr_data;
  logic        mem_wr_en;
  logic [4:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        out_valid, out_ready;
  logic [31:0] out_op_a, out_op_b, out_imm, out_pc, stall_cnt;
  logic [4:0]  out_rd;
  logic [15:0] out_ctrl;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(32), .REG_AW(5), .CTRL_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_imm(in_imm), .in_pc(in_pc), .in_ctrl(in_ctrl),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rd(out_rd),
    .out_imm(out_imm), .out_pc(out_pc), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_rs1 = '0; in_rs2 = '0; in_use_rs1 = 1'b1; in_use_rs2 = 1'b1;
    in_rd = '0; in_imm = '0; in_pc = '0; in_ctrl = '0;
    rf_rdata_a = '0; rf_rdata_b = '0;
    ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_wr_addr = '0; ex_wr_data = '0;
    mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;

    // 1 reset held two cycles with in_valid high
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_op_a", out_op_a, 0);
    check("rst_pc", out_pc, 0);
    reset = 1'b0; in_valid = 1'b0;
    #1 check("rst_in_ready", in_ready, 1);

    // 2 RF read, rs2 = x0
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd0;
    rf_rdata_a = 32'h1234; rf_rdata_b = 32'hDEAD;
    in_rd = 5'd9; in_imm = 32'hCAFE_0001; in_pc = 32'h0000_0100; in_ctrl = 16'hA5A5;
    #1 check("rf_raddr_a", rf_raddr_a, 5);
    check("rf_raddr_b", rf_raddr_b, 0);
    step();
    in_valid = 1'b0;
    check("rf_out_valid", out_valid, 1);
    check("rf_op_a", out_op_a, 32'h1234);
    check("rf_op_b_x0", out_op_b, 0);
    check("rf_rd", out_rd, 9);
    check("rf_imm", out_imm, 32'hCAFE_0001);
    check("rf_pc", out_pc, 32'h100);
    check("rf_ctrl", out_ctrl, 16'hA5A5);
    step();
    check("drain_valid", out_valid, 0);

    // 3 forwarding priority EX > MEM > RF, then MEM > RF (back-to-back)
    in_valid = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd3;
    rf_rdata_a = 32'h1111; rf_rdata_b = 32'h2222;
    ex_wr_en = 1'b1; ex_wr_addr = 5'd3; ex_wr_data = 32'hAAAA;
    mem_wr_en = 1'b1; mem_wr_addr = 5'd3; mem_wr_data = 32'hBBBB;
    step();
    check("fwd_ex_a", out_op_a, 32'hAAAA);
    check("fwd_ex_b", out_op_b, 32'hAAAA);
    ex_wr_en = 1'b0;
    step();
    check("b2b_valid", out_valid, 1);
    check("fwd_mem_a", out_op_a, 32'hBBBB);
    check("fwd_mem_b", out_op_b, 32'hBBBB);
    in_valid = 1'b0; mem_wr_en = 1'b0;
    step();

    // 4 load-use on rs2
    in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd7;
    rf_rdata_a = 32'h10; rf_rdata_b = 32'h99;
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 5'd7; ex_wr_data = 32'hEEEE;
    #1 check("lu_in_ready", in_ready, 0);
    step();
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu_no_accept", out_valid, 0);
    ex_wr_en = 1'b0; ex_is_load = 1'b0;
    mem_wr_en = 1'b1; mem_wr_addr = 5'd7; mem_wr_data = 32'h55;
    #1 check("lu_ready_after", in_ready, 1);
    step();
    check("lu_valid", out_valid, 1);
    check("lu_op_b_mem", out_op_b, 32'h55);
    check("lu_op_a_rf", out_op_a, 32'h10);
    check("lu_stall_hold", stall_cnt, 1);
    in_valid = 1'b0; mem_wr_en = 1'b0;
    step();

    // 4b same load but rs2 unused: no stall, RF value taken
    in_valid = 1'b1; in_use_rs2 = 1'b0; rf_rdata_b = 32'h77;
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 5'd7;
    #1 check("nolu_in_ready", in_ready, 1);
    step();
    check("nolu_stall_cnt", stall_cnt, 1);
    check("nolu_valid", out_valid, 1);
    check("nolu_op_b", out_op_b, 32'h77);
    in_use_rs2 = 1'b1; ex_wr_en = 1'b0; ex_is_load = 1'b0;

    // 5 backpressure: entry (0x10, 0x77) held while new input waits
    out_ready = 1'b0; in_rs1 = 5'd2; in_rs2 = 5'd4;
    rf_rdata_a = 32'h2222; rf_rdata_b = 32'h4444;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_in_ready", in_ready, 0);
      step();
      check("bp_valid", out_valid, 1);
      check("bp_op_a", out_op_a, 32'h10);
      check("bp_op_b", out_op_b, 32'h77);
    end
    flush = 1'b1;
    #1 check("fl_in_ready", in_ready, 0);
    step();
    check("fl_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("fl_not_consumed", out_valid, 0);

    // 6 x0 destinations never forward nor stall
    in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd0;
    rf_rdata_a = 32'h3333; rf_rdata_b = 32'h3333;
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 5'd0; ex_wr_data = 32'hFFFF;
    #1 check("x0_in_ready", in_ready, 1);
    step();
    check("x0_load_op_a", out_op_a, 0);
    check("x0_stall_cnt", stall_cnt, 1);
    ex_is_load = 1'b0;
    step();
    check("x0_alu_op_a", out_op_a, 0);
    check("x0_alu_op_b", out_op_b, 0);
    in_valid = 1'b0; ex_wr_en = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
